// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module : uart_arb_pkg
// Brief  : Shared types, constants and pointer helper for the UART TX arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int PTR_W  = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Successor of ptr in a ring of n entries; n need not be a power of two.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input int n);
    logic [PTR_W-1:0] v_next;
    v_next = ptr + 1'b1;
    if (int'(ptr) >= n - 1) begin
      v_next = '0;
    end
    return v_next;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
// Module : uart_rr_picker
// Brief  : Round-robin winner search starting at a pointer (double-width scan).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_mask;
  logic [2*NUM_REQ-1:0] w_scan;
  logic                 w_found;

  assign w_dbl = {i_req, i_req};

  // Masking the low copy below the pointer makes the first hit the
  // round-robin winner; the upper copy supplies the wrap-around.
  generate
    for (genvar g = 0; g < 2*NUM_REQ; g++) begin : g_mask
      assign w_mask[g] = (g >= int'(i_ptr));
    end
  endgenerate

  assign w_scan = w_dbl & w_mask;
  assign o_any  = |i_req;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      if (!w_found && w_scan[j]) begin
        w_found = 1'b1;
        o_idx   = IDX_W'(j % NUM_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Message-atomic round-robin arbiter feeding one UART TX byte channel.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int c_owner_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] i_req_bits,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_tx_valid,
  output logic [BYTE_W-1:0]         o_tx_bits,
  input  logic                      i_tx_ready,
  output logic [c_owner_w-1:0]      o_owner,
  output logic                      o_locked,
  output logic                      o_timeout
);

  localparam int c_idle_w = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [c_idle_w-1:0] c_idle_limit = c_idle_w'(IDLE_TIMEOUT - 1);
  localparam logic [c_idle_w-1:0] c_idle_max   = {c_idle_w{1'b1}};

  arb_state_t            r_state;
  logic [c_owner_w-1:0]  r_owner;
  logic [c_owner_w-1:0]  r_ptr;
  logic [c_idle_w-1:0]   r_idle;
  logic                  r_out_valid;
  logic [BYTE_W-1:0]     r_out_bits;
  logic                  r_timeout;

  logic [BYTE_W-1:0]     w_req_byte [NUM_REQ];
  logic                  w_any;
  logic [c_owner_w-1:0]  w_pick;
  logic [c_owner_w-1:0]  w_ptr_next;
  logic                  w_slot_free;
  logic                  w_owner_valid;
  logic                  w_accept;
  logic                  w_idle_hit;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_req_byte[g] = i_req_bits[g*BYTE_W +: BYTE_W];
    end
  endgenerate

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_owner_w)
  ) u_picker (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_idx   (w_pick)
  );

  assign w_slot_free   = !r_out_valid || i_tx_ready;
  assign w_owner_valid = i_req_valid[r_owner];
  assign w_accept      = (r_state == LOCKED) && w_owner_valid && w_slot_free;
  assign w_idle_hit    = (IDLE_TIMEOUT != 0) && (r_idle == c_idle_limit);
  assign w_ptr_next    = c_owner_w'(rr_next(PTR_W'(r_owner), NUM_REQ));

  // Ready follows the transmitter combinationally so a drain and a refill
  // can happen in the same cycle.
  always_comb begin
    o_req_ready = '0;
    if (r_state == LOCKED) begin
      o_req_ready[r_owner] = w_slot_free;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_idle      <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_bits  <= w_req_byte[r_owner];
      end else if (r_out_valid && i_tx_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_idle  <= '0;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_accept) begin
            r_idle <= '0;
            if (i_req_last[r_owner]) begin
              r_state <= IDLE;
              r_ptr   <= w_ptr_next;
            end
          end else if (!w_owner_valid) begin
            if (w_idle_hit) begin
              r_state   <= IDLE;
              r_timeout <= 1'b1;
              r_ptr     <= w_ptr_next;
              r_idle    <= '0;
            end else if (r_idle != c_idle_max) begin
              r_idle <= r_idle + 1'b1;
            end
          end else begin
            // Owner is presenting data but the slot is busy: not idle.
            r_idle <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_valid = r_out_valid;
  assign o_tx_bits  = r_out_bits;
  assign o_owner    = r_owner;
  assign o_locked   = (r_state == LOCKED);
  assign o_timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench: directed scenarios plus randomized traffic
//          compared against a message-level round-robin model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int IDLE_TIMEOUT = 16;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ*8-1:0] i_req_bits;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic                 o_tx_valid;
  logic [7:0]           o_tx_bits;
  logic                 i_tx_ready;
  logic [1:0]           o_owner;
  logic                 o_locked;
  logic                 o_timeout;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_bits  (i_req_bits),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_valid  (o_tx_valid),
    .o_tx_bits   (o_tx_bits),
    .i_tx_ready  (i_tx_ready),
    .o_owner     (o_owner),
    .o_locked    (o_locked),
    .o_timeout   (o_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  // Per-requester message streams: bit 8 is the last flag.
  logic [8:0] q_msg [NUM_REQ][$];
  int         gap   [NUM_REQ];
  logic [7:0] tx_log[$];
  int         acc_log[$];
  logic [7:0] exp_tx[$];
  int         exp_acc[$];
  int         n_tmo, n_multi, n_hold;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input logic [7:0] b, input bit l);
    i_req_valid[k]      = v;
    i_req_bits[8*k +: 8] = b;
    i_req_last[k]       = l;
  endtask

  task automatic clear_inputs();
    i_req_valid = '0;
    i_req_bits  = '0;
    i_req_last  = '0;
  endtask

  task automatic apply_reset();
    i_rst      = 1'b0;
    i_tx_ready = 1'b0;
    clear_inputs();
    for (int k = 0; k < NUM_REQ; k++) q_msg[k].delete();
    exp_tx.delete();
    exp_acc.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (q_msg[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive_heads();
    logic [8:0] h;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (q_msg[k].size() != 0 && gap[k] == 0) begin
        h = q_msg[k][0];
        set_req(k, 1'b1, h[7:0], h[8]);
      end else begin
        set_req(k, 1'b0, 8'h00, 1'b0);
      end
    end
  endtask

  // Requesters present their queued bytes; after a non-last byte a
  // requester may pause up to gap_max cycles. tx_ready is random except
  // inside [stall_lo, stall_hi) where it is held low.
  task automatic run_traffic(input int budget, input int ready_pct, input int gap_max,
                             input int stall_lo, input int stall_hi);
    int               cyc;
    bit               done;
    bit               prev_v;
    bit               prev_rdy;
    logic [7:0]       prev_b;
    logic [NUM_REQ-1:0] acc;
    logic [8:0]       h;
    cyc = 0; done = 1'b0; prev_v = 1'b0; prev_rdy = 1'b1; prev_b = '0;
    tx_log.delete(); acc_log.delete();
    n_tmo = 0; n_multi = 0; n_hold = 0;
    for (int k = 0; k < NUM_REQ; k++) gap[k] = 0;
    drive_heads();
    i_tx_ready = (stall_lo == 0 && stall_hi > 0) ? 1'b0 : ($urandom_range(99, 0) < ready_pct);
    while (!done && cyc < budget) begin
      @(negedge i_clk);
      if ($countones(o_req_ready) > 1) n_multi++;
      if (o_timeout) n_tmo++;
      if (prev_v && !prev_rdy && (!o_tx_valid || o_tx_bits != prev_b)) n_hold++;
      prev_v   = o_tx_valid;
      prev_rdy = i_tx_ready;
      prev_b   = o_tx_bits;
      if (o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_bits);
      acc  = i_req_valid & o_req_ready;
      done = (acc == '0) && queues_empty() && !o_tx_valid;
      if (!done) begin
        tick();
        for (int k = 0; k < NUM_REQ; k++) begin
          if (acc[k]) begin
            h = q_msg[k].pop_front();
            acc_log.push_back(k);
            gap[k] = h[8] ? 0 : int'($urandom_range(gap_max, 0));
          end else if (gap[k] > 0) begin
            gap[k]--;
          end
        end
        cyc++;
        drive_heads();
        i_tx_ready = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0
                                                        : ($urandom_range(99, 0) < ready_pct);
      end
    end
    check_eq("traffic_done", 32'(done), 32'd1);
    clear_inputs();
  endtask

  task automatic compare_logs(input string tag);
    check_eq({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      check_eq({tag, "_tx_byte"}, 32'(tx_log[i]), 32'(exp_tx[i]));
    check_eq({tag, "_acc_count"}, 32'(acc_log.size()), 32'(exp_acc.size()));
    for (int i = 0; i < acc_log.size() && i < exp_acc.size(); i++)
      check_eq({tag, "_acc_owner"}, 32'(acc_log[i]), 32'(exp_acc[i]));
  endtask

  initial begin
    int  len;
    int  cnt;
    logic [7:0] b;

    // Reset state
    apply_reset();
    check_eq("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check_eq("rst_tx_bits",  32'(o_tx_bits),  32'd0);
    check_eq("rst_ready",    32'(o_req_ready), 32'd0);
    check_eq("rst_owner",    32'(o_owner),    32'd0);
    check_eq("rst_locked",   32'(o_locked),   32'd0);
    check_eq("rst_timeout",  32'(o_timeout),  32'd0);

    // Basic grant: single-byte message from requester 0
    i_tx_ready = 1'b1;
    set_req(0, 1'b1, 8'h41, 1'b1);
    tick();
    check_eq("t1_locked",   32'(o_locked),    32'd1);
    check_eq("t1_ready",    32'(o_req_ready), 32'h1);
    check_eq("t1_notx",     32'(o_tx_valid),  32'd0);
    tick();
    check_eq("t1_tx_valid", 32'(o_tx_valid),  32'd1);
    check_eq("t1_tx_bits",  32'(o_tx_bits),   32'h41);
    check_eq("t1_unlocked", 32'(o_locked),    32'd0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    tick();
    check_eq("t1_drained",  32'(o_tx_valid),  32'd0);

    // No interleave: requester 1's message completes before requester 2
    apply_reset();
    q_msg[1] = '{9'h010, 9'h011, 9'h112};
    q_msg[2] = '{9'h120};
    exp_tx  = '{8'h10, 8'h11, 8'h12, 8'h20};
    exp_acc = '{1, 1, 1, 2};
    run_traffic(200, 100, 0, 0, 0);
    compare_logs("t2");
    check_eq("t2_one_ready", 32'(n_multi), 32'd0);

    // Round-robin fairness with four always-busy requesters
    apply_reset();
    for (int m = 0; m < 10; m++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        b = 8'(k*16 + m);
        q_msg[k].push_back({1'b1, b});
        exp_tx.push_back(b);
        exp_acc.push_back(k);
      end
    end
    run_traffic(400, 100, 0, 0, 0);
    compare_logs("t3");
    for (int k = 0; k < NUM_REQ; k++) begin
      cnt = 0;
      foreach (acc_log[i]) if (acc_log[i] == k) cnt++;
      check_eq("t3_share", 32'(cnt), 32'd10);
    end

    // Backpressure: 50 stalled cycles mid-message must not time out
    apply_reset();
    q_msg[0] = '{9'h0A1, 9'h0A2, 9'h1A3};
    exp_tx  = '{8'hA1, 8'hA2, 8'hA3};
    exp_acc = '{0, 0, 0};
    run_traffic(300, 100, 0, 2, 52);
    compare_logs("t4");
    check_eq("t4_no_timeout", 32'(n_tmo),  32'd0);
    check_eq("t4_hold",       32'(n_hold), 32'd0);

    // Timeout: owner 3 stalls after a non-last byte, requester 0 waits
    apply_reset();
    i_tx_ready = 1'b1;
    set_req(3, 1'b1, 8'h55, 1'b0);
    tick();
    check_eq("t5_owner3", 32'(o_owner),  32'd3);
    check_eq("t5_locked", 32'(o_locked), 32'd1);
    tick();
    check_eq("t5_tx55",   32'(o_tx_bits), 32'h55);
    set_req(3, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h66, 1'b1);
    for (int k = 1; k <= IDLE_TIMEOUT; k++) begin
      tick();
      check_eq("t5_timeout_pulse", 32'(o_timeout), 32'(k == IDLE_TIMEOUT));
      if (k == IDLE_TIMEOUT - 1) check_eq("t5_still_locked", 32'(o_locked), 32'd1);
    end
    check_eq("t5_released", 32'(o_locked), 32'd0);
    tick();
    check_eq("t5_pulse_gone", 32'(o_timeout), 32'd0);
    check_eq("t5_next_owner", 32'(o_owner),   32'd0);
    check_eq("t5_relocked",   32'(o_locked),  32'd1);
    tick();
    check_eq("t5_tx66",       32'(o_tx_bits), 32'h66);
    check_eq("t5_tx66_valid", 32'(o_tx_valid), 32'd1);
    clear_inputs();

    // Reset mid-message, with the pointer previously advanced past 2
    apply_reset();
    q_msg[2] = '{9'h1AA};
    run_traffic(50, 100, 0, 0, 0);
    i_tx_ready = 1'b0;
    set_req(1, 1'b1, 8'h31, 1'b0);
    tick();
    tick();
    check_eq("t6_pre_valid", 32'(o_tx_valid), 32'd1);
    check_eq("t6_pre_owner", 32'(o_owner),    32'd1);
    #3;
    i_rst = 1'b0;
    #2;
    check_eq("t6_async_valid",  32'(o_tx_valid),  32'd0);
    check_eq("t6_async_locked", 32'(o_locked),    32'd0);
    check_eq("t6_async_owner",  32'(o_owner),     32'd0);
    check_eq("t6_async_ready",  32'(o_req_ready), 32'd0);
    set_req(1, 1'b1, 8'h77, 1'b1);
    set_req(3, 1'b1, 8'h99, 1'b1);
    i_tx_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    check_eq("t6_restart_owner",  32'(o_owner),  32'd1);
    check_eq("t6_restart_locked", 32'(o_locked), 32'd1);
    clear_inputs();

    // Randomized traffic: saturated requesters must rotate 0,1,2,3,...
    apply_reset();
    for (int m = 0; m < 6; m++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        len = int'($urandom_range(4, 1));
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom);
          q_msg[k].push_back({(j == len - 1), b});
          exp_tx.push_back(b);
          exp_acc.push_back(k);
        end
      end
    end
    run_traffic(3000, 70, 4, 0, 0);
    compare_logs("rnd");
    check_eq("rnd_no_timeout", 32'(n_tmo),   32'd0);
    check_eq("rnd_one_ready",  32'(n_multi), 32'd0);
    check_eq("rnd_hold",       32'(n_hold),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
